// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector
//   Samples the registered serial bit stream coming out of the dflipflop stage
//   and detects a fixed PAT_LEN-bit pattern, first-received bit in the MSB.
//   Emits a one-cycle match pulse and keeps a saturating count of matches.
//   Overlapping or non-overlapping detection is chosen per edge by `overlap`.
//
// Handshake: there is no back-pressure. A bit is consumed on every rising edge
//   where en=1; edges with en=0 leave window, fill and match_count untouched
//   and drive match low.
//
// Ports
//   clock        in   1        rising-edge clock
//   reset        in   1        synchronous, active-high; overrides everything
//   en           in   1        sample enable
//   din          in   1        serial data input
//   overlap      in   1        1 = overlapping detection, 0 = non-overlapping
//   window       out  PAT_LEN  last PAT_LEN sampled bits, LSB newest
//   filled       out  1        fill counter has reached PAT_LEN
//   match        out  1        pattern completed at the previous edge
//   match_count  out  CNT_W    matches since reset, saturating
module serial_pattern_detector #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic               din,
  input  logic               overlap,
  output logic [PAT_LEN-1:0] window,
  output logic               filled,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);

  localparam int               FILL_W  = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  // Number of bits sampled since reset or since a non-overlapping match.
  // A window compare only counts once fill reaches PAT_LEN, so stale bits
  // left in the window after a clear can never produce a false hit.
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_inc;
  logic [FILL_W-1:0]  fill_d;
  logic [PAT_LEN-1:0] window_n;
  logic               hit;

  always_comb begin
    window_n = {window[PAT_LEN-2:0], din};
    fill_inc = (fill == FULL) ? FULL : fill + FILL_W'(1);
    hit      = en && (fill_inc == FULL) && (window_n == PATTERN);
    fill_d   = fill;
    if (en) begin
      if (hit) begin
        // Overlapping mode keeps the window armed so the very next bit may
        // complete another match; otherwise PAT_LEN fresh bits are needed.
        fill_d = overlap ? FULL : '0;
      end else begin
        fill_d = fill_inc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      window      <= '0;
      fill        <= '0;
      filled      <= 1'b0;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      if (en) begin
        window <= window_n;
      end
      fill   <= fill_d;
      // Registered copy of (fill == PAT_LEN) so the output is a flop.
      filled <= (fill_d == FULL);
      match  <= hit;
      if (hit && (match_count != CNT_MAX)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Bench for serial_pattern_detector. Three instances share one stimulus
// stream: the default configuration, a 2-bit counter variant and an
// all-ones pattern variant. A behavioural model per instance pushes the
// expected {match, filled, window, count} word into a queue when a bit is
// driven; the word is popped and compared after the following rising edge.
// Directed checks mark the headline results of each scenario.
module tb_serial_pattern_detector;

  localparam int W = 14;  // {match, filled, window[3:0], count[7:0]}

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic din = 1'b0;
  logic overlap = 1'b0;

  logic [3:0] win0, win1, win2;
  logic       fil0, fil1, fil2;
  logic       mat0, mat1, mat2;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [7:0] cnt2;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];

  // Reference model state, one slot per instance.
  logic [3:0] m_pat [3] = '{4'b1011, 4'b1011, 4'b1111};
  int         m_max [3] = '{255, 3, 255};
  logic [3:0] m_win [3];
  int         m_fill[3];
  logic       m_mat [3];
  int         m_cnt [3];

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- DUTs ----------------
  serial_pattern_detector dut (
    .clock(clock), .reset(reset), .en(en), .din(din), .overlap(overlap),
    .window(win0), .filled(fil0), .match(mat0), .match_count(cnt0)
  );

  serial_pattern_detector #(.CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .en(en), .din(din), .overlap(overlap),
    .window(win1), .filled(fil1), .match(mat1), .match_count(cnt1)
  );

  serial_pattern_detector #(.PATTERN(4'b1111)) dut_ones (
    .clock(clock), .reset(reset), .en(en), .din(din), .overlap(overlap),
    .window(win2), .filled(fil2), .match(mat2), .match_count(cnt2)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [W-1:0] model_step(input int i, input logic r, input logic e,
                                              input logic d, input logic ov);
    logic [3:0] shifted;
    int         nf;
    logic       h;
    if (r) begin
      m_win[i] = 4'b0000; m_fill[i] = 0; m_mat[i] = 1'b0; m_cnt[i] = 0;
    end else if (e) begin
      shifted = {m_win[i][2:0], d};
      nf = (m_fill[i] >= 4) ? 4 : m_fill[i] + 1;
      h = (nf == 4) && (shifted == m_pat[i]);
      m_win[i] = shifted;
      m_mat[i] = h;
      if (h) m_fill[i] = ov ? 4 : 0;
      else   m_fill[i] = nf;
      if (h && m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
    end else begin
      m_mat[i] = 1'b0;
    end
    return {m_mat[i], (m_fill[i] == 4), m_win[i], 8'(m_cnt[i])};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic e, input logic d, input logic ov);
    @(negedge clock);
    reset = r; en = e; din = d; overlap = ov;
    exp_q0.push_back(model_step(0, r, e, d, ov));
    exp_q1.push_back(model_step(1, r, e, d, ov));
    exp_q2.push_back(model_step(2, r, e, d, ov));
    @(posedge clock);
    #1;
    check("sb_dut",      32'({mat0, fil0, win0, cnt0}),       32'(exp_q0.pop_front()));
    check("sb_dut_sat",  32'({mat1, fil1, win1, 6'd0, cnt1}), 32'(exp_q1.pop_front()));
    check("sb_dut_ones", 32'({mat2, fil2, win2, cnt2}),       32'(exp_q2.pop_front()));
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0]  s7;
    logic [19:0] s20;

    // Reset state
    do_reset();
    check("rst_window", 32'(win0), 32'h0);
    check("rst_filled", 32'(fil0), 32'h0);
    check("rst_match",  32'(mat0), 32'h0);
    check("rst_count",  32'(cnt0), 32'h0);

    // 1: overlapping, 1011011 -> pulses after bits 4 and 7
    s7 = 7'b1011011;
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b1, s7[7-k], 1'b1);
      if (k == 4 || k == 7) begin
        check("t1_match", 32'(mat0), 32'h1);
        check("t1_window", 32'(win0), 32'hb);
      end else begin
        check("t1_nomatch", 32'(mat0), 32'h0);
      end
    end
    check("t1_count", 32'(cnt0), 32'd2);

    // 2: non-overlapping, same stream -> one pulse after bit 4
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b1, s7[7-k], 1'b0);
      if (k == 4) begin
        check("t2_match", 32'(mat0), 32'h1);
        check("t2_filled", 32'(fil0), 32'h0);
      end else begin
        check("t2_nomatch", 32'(mat0), 32'h0);
      end
    end
    check("t2_count", 32'(cnt0), 32'd1);

    // 3: reset mid-stream discards progress
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("t3_match",  32'(mat0), 32'h0);
    check("t3_window", 32'(win0), 32'h1);
    check("t3_count",  32'(cnt0), 32'h0);

    // 4: gated bit is ignored
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t4_gated_window", 32'(win0), 32'h2);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("t4_match",  32'(mat0), 32'h1);
    check("t4_window", 32'(win0), 32'hb);

    // 5: saturation on the 2-bit counter instance
    do_reset();
    s20 = {5{4'b1011}};
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b1, s20[20-k], 1'b1);
      if (k % 4 == 0) check("t5_match", 32'(mat1), 32'h1);
    end
    check("t5_count_sat", 32'(cnt1), 32'd3);
    check("t5_count_wide", 32'(cnt0), 32'd5);

    // 6: all-ones pattern, consecutive hits
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("t6_match", 32'(mat2), (k >= 4) ? 32'h1 : 32'h0);
    end
    check("t6_count", 32'(cnt2), 32'd3);

    // Random traffic with random enable and overlap, scoreboard only
    do_reset();
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
